s27_scan_bist: RTL
==================

S27_SCAN_BIST -- requirements
Module: s27_scan_bist

Interface
REQ-001 SHALL have parameter N, default 4: number of independent s27-style channels, 1..W.
REQ-002 SHALL have parameter W, default 16: signature register width.
REQ-003 SHALL have parameter POLY, default 16'h1021: MISR feedback polynomial, W bits.
REQ-004 SHALL have parameter SEED, default all-ones: MISR reset value, W bits.
REQ-005 SHALL have parameter LEN, default 256: BIST run length in cycles, at least 1.
REQ-006 SHALL use one clock and a synchronous, active-high reset: CK input 1, rising-edge clock; RST input 1, synchronous active-high reset.
REQ-007 SHALL have these ports: G0, G1, G2, G3 input N each, per-channel primary inputs; G17 output N, per-channel primary output.
REQ-008 SHALL have these scan ports: SE input 1, scan enable; SI input 1, scan in; SO output 1, scan out.
REQ-009 SHALL have these BIST ports: START input 1, BIST start pulse; BUSY output 1, run active; DONE output 1, run complete; SIG output W, MISR contents.

Function
REQ-010 SHALL give each channel c three state flops S5[c], S6[c], S7[c], with combinational terms:
- A = ~G0
- B = ~(G1|S7)
- C = ~(G2|B)
- D = A&S6
- E = ~((G3|D)&(B|D))
- F = ~(S5|E)
REQ-011 SHALL drive G17[c] = ~F, combinationally from current state and inputs.
REQ-012 SHALL, when SE=0, load S5 <= ~(A|F), S6 <= F, S7 <= C each cycle.
REQ-013 SHALL, when SE=1, shift all 3N flops one position per cycle:
- order SI -> S5[0] -> S6[0] -> S7[0] -> S5[1] -> ... -> S7[N-1]
- SO = S7[N-1], a registered value.
REQ-014 SHALL run an FSM with states IDLE, RUN, DONE: BUSY = (state==RUN), DONE = (state==DONE).
REQ-015 SHALL move IDLE->RUN on START=1 with SE=0; entering RUN loads SIG <= SEED and clears the cycle counter.
REQ-016 SHALL, in RUN with SE=0, perform per cycle:
- SIG <= (SIG<<1) ^ (SIG[W-1] ? POLY : 0) ^ zero-extend(G17)
- counter += 1
- move RUN->DONE when the counter reaches LEN; exactly LEN updates occur.
REQ-017 SHALL hold SIG in DONE; START in DONE returns the FSM to RUN and reseeds per REQ-015.
REQ-018 SHALL, while SE=1, freeze the FSM, counter and SIG, and ignore START.
REQ-019 SHALL size the counter as clog2(LEN+1) bits, with no wrap before LEN.
REQ-020 SHALL ignore START while in RUN.

Reset
REQ-021 SHALL, on RST=1 at a CK edge, give all state flops 0, SIG=SEED, counter 0, FSM IDLE, BUSY=0, DONE=0, SO=0.
REQ-022 SHALL give RST priority over SE and START; a reset mid-RUN aborts the run with no DONE.
REQ-023 SHALL, after reset with all G inputs 0, drive G17 all-ones.

Structure
REQ-024 SHALL place the FSM state enum and the default POLY/SEED constants in the shared package s27_pkg.
REQ-025 SHALL use one sub-module, s27_core: a single channel with 3 scan-muxed flops, scan in/out, and sync reset, instantiated N times and chained.
REQ-026 SHALL use no latches and no asynchronous logic.

Verification
REQ-027 SHALL cover reset: N=1, RST, all G=0 -> G17=1 and next state {S5,S6,S7}=000.
REQ-028 SHALL cover functional capture: N=1 from reset, G0=1, G3=1, G1=G2=0 -> G17=0; after one CK, {S5,S6,S7}=010.
REQ-029 SHALL cover scan: N=1, SE=1, SI sequence 1,0,1 over 3 cycles -> {S5,S6,S7}=101, SO=1; SIG and FSM unchanged.
REQ-030 SHALL cover a single-step BIST: N=1, LEN=1, W=16, SEED=FFFF, POLY=1021, all G=0, START pulse -> one cycle later SIG=EFDE, DONE=1, BUSY=0.
REQ-031 SHALL cover a full run against a model: N=4, LEN=256, random G with SE toggled mid-run -> SIG matches the reference model; the freeze cycles are excluded from the count.
REQ-032 SHALL cover reset mid-RUN: RST in cycle 10 of RUN -> IDLE, SIG=SEED, DONE never asserted.

Source files
------------

// File: rtl/s27_pkg.sv
// Shared definitions for the s27 scan/BIST block: FSM encoding and MISR defaults.
package s27_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } bist_state_t;

   localparam logic [15:0] POLY_DEFAULT = 16'h1021;
   localparam logic [15:0] SEED_DEFAULT = 16'hFFFF;

endpackage

// File: rtl/s27_core.sv
// One s27 channel: three state flops with a scan mux in front of each flop.
module s27_core (
   input  logic ck,
   input  logic rst,
   input  logic se,
   input  logic si,
   input  logic g0,
   input  logic g1,
   input  logic g2,
   input  logic g3,
   output logic g17,
   output logic so
);

   logic s5, s6, s7;
   logic a, b, c, d, e, f;

   assign a   = ~g0;
   assign b   = ~(g1 | s7);
   assign c   = ~(g2 | b);
   assign d   = a & s6;
   assign e   = ~((g3 | d) & (b | d));
   assign f   = ~(s5 | e);
   assign g17 = ~f;
   assign so  = s7;

   always_ff @(posedge ck) begin
      if (rst) begin
         s5 <= 1'b0;
         s6 <= 1'b0;
         s7 <= 1'b0;
      end else if (se) begin
         s5 <= si;
         s6 <= s5;
         s7 <= s6;
      end else begin
         s5 <= ~(a | f);
         s6 <= f;
         s7 <= c;
      end
   end

endmodule

// File: rtl/s27_scan_bist.sv
// N chained s27 channels with a shared scan path and a MISR-based BIST run controller.
module s27_scan_bist
   import s27_pkg::*;
#(
   parameter int              N    = 4,
   parameter int              W    = 16,
   parameter logic [W-1:0]    POLY = W'(POLY_DEFAULT),
   parameter logic [W-1:0]    SEED = {W{SEED_DEFAULT[0]}},
   parameter int              LEN  = 256
) (
   input  logic         CK,
   input  logic         RST,
   input  logic [N-1:0] G0,
   input  logic [N-1:0] G1,
   input  logic [N-1:0] G2,
   input  logic [N-1:0] G3,
   output logic [N-1:0] G17,
   input  logic         SE,
   input  logic         SI,
   output logic         SO,
   input  logic         START,
   output logic         BUSY,
   output logic         DONE,
   output logic [W-1:0] SIG
);

   localparam int             CW   = $clog2(LEN + 1);
   localparam logic [CW-1:0]  LAST = CW'(LEN - 1);

   bist_state_t   state;
   logic [CW-1:0] cnt;
   logic [W-1:0]  misr_next;
   logic [N:0]    link;

   assign link[0] = SI;
   assign SO      = link[N];

   for (genvar ch = 0; ch < N; ch++) begin : g_ch
      s27_core u_core (
         .ck  (CK),
         .rst (RST),
         .se  (SE),
         .si  (link[ch]),
         .g0  (G0[ch]),
         .g1  (G1[ch]),
         .g2  (G2[ch]),
         .g3  (G3[ch]),
         .g17 (G17[ch]),
         .so  (link[ch+1])
      );
   end

   always_comb begin
      misr_next = (SIG << 1) ^ (SIG[W-1] ? POLY : '0) ^ W'(G17);
   end

   assign BUSY = (state == ST_RUN);
   assign DONE = (state == ST_DONE);

   // Scan mode freezes the whole BIST controller, so a run can be paused for a scan dump.
   always_ff @(posedge CK) begin
      if (RST) begin
         state <= ST_IDLE;
         cnt   <= '0;
         SIG   <= SEED;
      end else if (!SE) begin
         case (state)
            ST_IDLE, ST_DONE: begin
               if (START) begin
                  state <= ST_RUN;
                  cnt   <= '0;
                  SIG   <= SEED;
               end
            end
            ST_RUN: begin
               SIG <= misr_next;
               cnt <= cnt + 1'b1;
               if (cnt == LAST) state <= ST_DONE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule
